// File: rtl/instr_mem_pkg.sv
// Shared types and sizing helpers for the instruction memory and its loader.
package instr_mem_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        LOAD  = 2'd2
    } state_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Single-write / single-read instruction RAM; READ_LAT registers the read path.
module instr_mem_array
    import instr_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_now;

    always_ff @(posedge clk)
        if (we) mem[wr_addr] <= wr_data;

    assign rd_now = mem[rd_addr];

    if (READ_LAT == 0) begin : g_rd_comb
        assign rd_data = rd_now;
    end else begin : g_rd_reg
        // Registered read samples the pre-write word on a same-address collision.
        logic [READ_LAT-1:0][DATA_W-1:0] rd_q;
        always_ff @(posedge clk) begin
            rd_q[0] <= rd_now;
            for (int i = 1; i < READ_LAT; i++)
                rd_q[i] <= rd_q[i-1];
        end
        assign rd_data = rd_q[READ_LAT-1];
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with streaming loader and sequential clear sweep.
module instr_mem_loader
    import instr_mem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = 0
) (
    input  logic              clk,
    input  logic              inst_reset_n,
    input  logic              clear_req,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_overflow,
    output logic [ADDR_W:0]   load_count,
    output logic              busy,
    input  logic [ADDR_W-1:0] pc_output,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid
);
    localparam int                DEPTH     = depth_of(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W+1)'(DEPTH);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_ptr, wr_ptr;
    logic              beat;
    logic              fetch_en;
    wr_req_t           wr_req;
    logic [DATA_W-1:0] rd_data;
    logic [READ_LAT:0] vld_pipe;

    // An abort wins over a beat presented in the same cycle.
    assign beat = (state == LOAD) && load_valid && !clear_req;

    always_ff @(posedge clk or negedge inst_reset_n)
        if (!inst_reset_n) state <= CLEAR;
        else               state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (clr_ptr == LAST_ADDR) state_nxt = IDLE;
            IDLE:    if (clear_req)            state_nxt = CLEAR;
                     else if (load_start)      state_nxt = LOAD;
            LOAD:    if (clear_req)            state_nxt = CLEAR;
                     else if (beat && load_last) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy         = (state == CLEAR);
        load_ready   = (state == LOAD);
        fetch_en     = (state != CLEAR);
        wr_req.en    = 1'b0;
        wr_req.addr  = wr_ptr;
        wr_req.data  = load_data;
        if (state == CLEAR) begin
            wr_req.en   = 1'b1;
            wr_req.addr = clr_ptr;
            wr_req.data = '0;
        end else if (beat) begin
            wr_req.en   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge inst_reset_n) begin
        if (!inst_reset_n) begin
            clr_ptr       <= '0;
            wr_ptr        <= '0;
            load_count    <= '0;
            load_overflow <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            load_done <= beat && load_last;
            case (state)
                CLEAR: clr_ptr <= clr_ptr + 1'b1;
                IDLE: begin
                    if (clear_req) begin
                        clr_ptr       <= '0;
                        load_count    <= '0;
                        load_overflow <= 1'b0;
                    end else if (load_start) begin
                        wr_ptr        <= load_base;
                        load_count    <= '0;
                        load_overflow <= 1'b0;
                    end
                end
                LOAD: begin
                    if (clear_req) begin
                        clr_ptr       <= '0;
                        load_count    <= '0;
                        load_overflow <= 1'b0;
                    end else if (beat) begin
                        wr_ptr <= wr_ptr + 1'b1;
                        if (load_count != CNT_MAX)
                            load_count <= load_count + 1'b1;
                        // The last beat landing on the top word is not a wrap.
                        if (!load_last && wr_ptr == LAST_ADDR)
                            load_overflow <= 1'b1;
                    end
                end
                default: clr_ptr <= '0;
            endcase
        end
    end

    instr_mem_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (READ_LAT)
    ) u_array (
        .clk     (clk),
        .we      (wr_req.en),
        .wr_addr (wr_req.addr),
        .wr_data (wr_req.data),
        .rd_addr (pc_output),
        .rd_data (rd_data)
    );

    // Fetch qualifier travels alongside the read data so it lines up at any latency.
    if (READ_LAT == 0) begin : g_vld_comb
        assign vld_pipe = fetch_en;
    end else begin : g_vld_reg
        logic [READ_LAT-1:0] vld_q;
        always_ff @(posedge clk or negedge inst_reset_n)
            if (!inst_reset_n) vld_q <= '0;
            else               vld_q <= (vld_q << 1) | READ_LAT'(fetch_en);
        assign vld_pipe = {vld_q, fetch_en};
    end

    assign instr_valid = vld_pipe[READ_LAT];
    assign instr       = vld_pipe[READ_LAT] ? rd_data : '0;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Random-stimulus bench: a 256-word combinational-read instance and a 16-word
// registered-read instance run in lockstep against an array-level reference model.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        inst_reset_n = 1'b0;
    logic        clear_req, load_start, load_valid, load_last;
    logic [7:0]  load_base, pc;
    logic [31:0] load_data;

    logic        ready_a, done_a, ovf_a, busy_a, iv_a;
    logic [8:0]  cnt_a;
    logic [31:0] instr_a;
    logic        ready_b, done_b, ovf_b, busy_b, iv_b;
    logic [4:0]  cnt_b;
    logic [31:0] instr_b;

    logic [31:0] ref_a [256];
    logic [31:0] ref_b [16];
    logic [31:0] bdata [$];
    int          n_vec, n_err;

    always #5 clk = ~clk;

    instr_mem_loader #(.DATA_W(32), .ADDR_W(8), .READ_LAT(0)) u_dut_a (
        .clk(clk), .inst_reset_n(inst_reset_n), .clear_req(clear_req),
        .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(ready_a),
        .load_done(done_a), .load_overflow(ovf_a), .load_count(cnt_a),
        .busy(busy_a), .pc_output(pc), .instr(instr_a), .instr_valid(iv_a)
    );

    instr_mem_loader #(.DATA_W(32), .ADDR_W(4), .READ_LAT(1)) u_dut_b (
        .clk(clk), .inst_reset_n(inst_reset_n), .clear_req(clear_req),
        .load_start(load_start), .load_base(load_base[3:0]), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(ready_b),
        .load_done(done_b), .load_overflow(ovf_b), .load_count(cnt_b),
        .busy(busy_b), .pc_output(pc[3:0]), .instr(instr_b), .instr_valid(iv_b)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Called at the first negedge that shows the sweep; counts busy cycles.
    task automatic wait_sweep(input int exp_a, input int exp_b);
        int ca = 0, cb = 0;
        bit bad_a = 0, bad_b = 0, bad_done = 0;
        for (int i = 0; i < 2000 && (busy_a || busy_b); i++) begin
            if (busy_a) begin
                if (iv_a || instr_a != 0 || ready_a) bad_a = 1;
                ca++;
            end
            if (busy_b) begin
                if (cb > 0 && (iv_b || instr_b != 0)) bad_b = 1;
                if (ready_b) bad_b = 1;
                cb++;
            end
            if (done_a || done_b) bad_done = 1;
            @(negedge clk);
        end
        chk("sweep_done", 64'(busy_a | busy_b), 64'(0));
        chk("sweep_len_a", 64'(ca), 64'(exp_a));
        chk("sweep_len_b", 64'(cb), 64'(exp_b));
        chk("sweep_quiet_a", 64'(bad_a), 64'(0));
        chk("sweep_quiet_b", 64'(bad_b), 64'(0));
        chk("sweep_no_done", 64'(bad_done), 64'(0));
        chk("post_sweep_iv", 64'({iv_a, iv_b}), 64'(2'b11));
        chk("post_sweep_cnt", 64'({cnt_a, cnt_b}), 64'(0));
        for (int i = 0; i < 256; i++) ref_a[i] = '0;
        for (int i = 0; i < 16; i++)  ref_b[i] = '0;
    endtask

    // Instance b is checked one cycle after each pc change.
    task automatic read_many(input int n, input bit rnd, input logic [7:0] start);
        logic [7:0] prev = '0;
        bit have = 0;
        for (int i = 0; i <= n; i++) begin
            if (have) chk("instr_b", 64'(instr_b), 64'(ref_b[prev[3:0]]));
            if (i == n) break;
            pc = rnd ? 8'($urandom) : 8'(int'(start) + i);
            #1;
            chk("instr_a", 64'(instr_a), 64'(ref_a[pc]));
            prev = pc;
            have = 1;
            @(negedge clk);
        end
    endtask

    task automatic burst(input logic [7:0] base, input int n, input int gap_pct,
                         input logic [31:0] vpat, input int plen);
        int  beats = 0, cyc = 0;
        bit  rdy_bad = 0, v;
        load_start = 1; load_base = base;
        @(negedge clk);
        load_start = 0;
        while (beats < n) begin
            if (cyc > 4 * n + 100) begin
                chk("burst_timeout", 64'(1), 64'(0));
                break;
            end
            if (!ready_a || !ready_b) rdy_bad = 1;
            v = (plen > 0 && cyc < plen) ? vpat[cyc] : ($urandom_range(99) >= gap_pct);
            load_valid = v;
            if (v) begin
                load_data = bdata[beats];
                load_last = (beats == n - 1);
                ref_a[(int'(base) + beats) % 256] = load_data;
                ref_b[(int'(base[3:0]) + beats) % 16] = load_data;
                beats++;
            end
            cyc++;
            @(negedge clk);
        end
        load_valid = 0; load_last = 0;
        chk("ready_in_load", 64'(rdy_bad), 64'(0));
        chk("done_a", 64'(done_a), 64'(1));
        chk("done_b", 64'(done_b), 64'(1));
        chk("count_a", 64'(cnt_a), 64'((n > 256) ? 256 : n));
        chk("count_b", 64'(cnt_b), 64'((n > 16) ? 16 : n));
        chk("ovf_a", 64'(ovf_a), 64'((int'(base) + n - 1) >= 256));
        chk("ovf_b", 64'(ovf_b), 64'((int'(base[3:0]) + n - 1) >= 16));
        chk("idle_ready", 64'({ready_a, ready_b}), 64'(0));
        @(negedge clk);
        chk("done_pulse", 64'({done_a, done_b}), 64'(0));
    endtask

    task automatic rand_data(input int n);
        bdata.delete();
        for (int i = 0; i < n; i++) bdata.push_back($urandom);
    endtask

    initial begin
        logic [31:0] old_b;
        n_vec = 0; n_err = 0;
        clear_req = 0; load_start = 0; load_valid = 0; load_last = 0;
        load_base = '0; load_data = '0; pc = '0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 64'({busy_a, busy_b}), 64'(2'b11));
        chk("rst_ready", 64'({ready_a, ready_b}), 64'(0));
        chk("rst_flags", 64'({done_a, ovf_a, done_b, ovf_b}), 64'(0));
        chk("rst_count", 64'({cnt_a, cnt_b}), 64'(0));
        chk("rst_iv", 64'({iv_a, iv_b}), 64'(0));
        chk("rst_instr", 64'({instr_a, instr_b}), 64'(0));

        inst_reset_n = 1;
        wait_sweep(256, 16);
        read_many(256, 0, 8'h00);

        bdata = '{32'h20080005, 32'h2009000A, 32'h01095020};
        burst(8'h10, 3, 0, 32'h0, 0);
        read_many(4, 0, 8'h10);

        rand_data(3);
        burst(8'h30, 3, 0, 32'b11001, 5);
        read_many(4, 0, 8'h30);

        bdata = '{32'hA, 32'hB, 32'hC, 32'hD};
        burst(8'hFE, 4, 0, 32'h0, 0);
        read_many(4, 0, 8'hFE);

        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(24, 1);
            rand_data(n);
            burst(8'($urandom), n, 30, 32'h0, 0);
            read_many(12, 1, 8'h00);
        end

        rand_data(260);
        burst(8'($urandom), 260, 0, 32'h0, 0);
        read_many(40, 1, 8'h00);

        // same-cycle read and write of one address
        load_start = 1; load_base = 8'h25;
        @(negedge clk);
        load_start = 0;
        old_b = ref_b[5];
        pc = 8'h25; load_valid = 1; load_last = 1; load_data = 32'h12345678;
        @(negedge clk);
        load_valid = 0; load_last = 0;
        chk("rdw_a_new", 64'(instr_a), 64'(32'h12345678));
        chk("rdw_b_old", 64'(instr_b), 64'(old_b));
        ref_a[8'h25] = 32'h12345678; ref_b[5] = 32'h12345678;
        @(negedge clk);
        chk("rdw_b_new", 64'(instr_b), 64'(32'h12345678));

        // clear_req beats load_start in IDLE
        load_start = 1; clear_req = 1; load_base = 8'h00;
        @(negedge clk);
        load_start = 0; clear_req = 0;
        chk("prio_busy", 64'({busy_a, busy_b}), 64'(2'b11));
        chk("prio_ready", 64'({ready_a, ready_b}), 64'(0));
        wait_sweep(256, 16);
        read_many(8, 1, 8'h00);

        // abort a burst on its second beat
        rand_data(2);
        load_start = 1; load_base = 8'h40;
        @(negedge clk);
        load_start = 0; load_valid = 1; load_data = bdata[0];
        @(negedge clk);
        load_data = bdata[1]; clear_req = 1;
        @(negedge clk);
        load_valid = 0; clear_req = 0;
        chk("abort_busy", 64'({busy_a, busy_b}), 64'(2'b11));
        chk("abort_no_done", 64'({done_a, done_b}), 64'(0));
        wait_sweep(256, 16);
        chk("abort_ovf", 64'({ovf_a, ovf_b}), 64'(0));
        read_many(256, 0, 8'h00);

        // reset in the middle of a burst
        rand_data(8);
        load_start = 1; load_base = 8'h80;
        @(negedge clk);
        load_start = 0; load_valid = 1; load_data = bdata[0];
        @(negedge clk);
        inst_reset_n = 0; load_valid = 0;
        #1;
        chk("midrst_busy", 64'({busy_a, busy_b}), 64'(2'b11));
        chk("midrst_ready", 64'({ready_a, ready_b}), 64'(0));
        chk("midrst_count", 64'({cnt_a, cnt_b}), 64'(0));
        chk("midrst_iv", 64'({iv_a, iv_b}), 64'(0));
        @(negedge clk);
        inst_reset_n = 1;
        wait_sweep(256, 16);
        read_many(20, 1, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Parametrised instruction memory for the single-cycle MIPS datapath, generalised in data width, depth and read latency. Adds a valid/ready streaming loader with auto-incrementing write pointer and a sequential clear engine that replaces the one-cycle bulk reset. Sits between the PC register and the decoder; the testbench or boot host fills it through the load port before the core is released.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 8, word-address width; DEPTH = 2**ADDR_W entries
READ_LAT, 0, fetch latency: 0 = combinational read, 1 = registered read

Ports:
clk  in  1  clock, all state on rising edge
inst_reset_n  in  1  asynchronous active-low reset
clear_req  in  1  one-cycle request to re-clear the whole array
load_start  in  1  one-cycle pulse that opens a load burst at load_base
load_base  in  ADDR_W  first word address of the burst
load_valid  in  1  load_data is valid this cycle
load_last  in  1  qualifies the final beat of the burst
load_data  in  DATA_W  instruction word to write
load_ready  out  1  loader accepts a beat this cycle
load_done  out  1  one-cycle pulse after the last beat is written
load_overflow  out  1  sticky: burst wrapped past DEPTH-1
load_count  out  ADDR_W+1  beats accepted in the current or last burst
busy  out  1  clear sweep in progress
pc_output  in  ADDR_W  fetch word address
instr  out  DATA_W  fetched instruction
instr_valid  out  1  instr is meaningful

Behaviour:
- Reset is asynchronous and active-low on inst_reset_n. The single clock is clk.
- Reset values: state=CLEAR, clr_ptr=0, wr_ptr=0, load_ready=0, load_done=0, load_overflow=0, load_count=0, busy=1, instr_valid=0, instr=0. The array itself is not reset; it is cleared by the sweep.
- FSM states: CLEAR, IDLE, LOAD.
- CLEAR: each cycle writes mem[clr_ptr]=0 and increments clr_ptr. When clr_ptr==DEPTH-1, the FSM moves to IDLE. The sweep takes exactly DEPTH cycles. busy=1, load_ready=0 and instr_valid=0 throughout.
- IDLE:
  - clear_req -> CLEAR with clr_ptr=0. This also clears load_overflow and load_count.
  - else load_start -> LOAD with wr_ptr=load_base, load_count=0, load_overflow=0.
  - clear_req has priority when both are asserted.
- LOAD: load_ready=1.
  - A beat transfers when load_valid && load_ready. It writes mem[wr_ptr]=load_data, then wr_ptr+1 (mod DEPTH) and load_count+1.
  - A beat with load_last transfers -> IDLE. load_done pulses high for one cycle on the following cycle.
  - A non-last beat accepted at wr_ptr==DEPTH-1 wraps wr_ptr to 0 and sets load_overflow. The flag stays set until the next load_start or clear.
  - load_start in LOAD is ignored.
  - clear_req in LOAD aborts the burst -> CLEAR. No load_done is issued; beats already written stay until the sweep overwrites them.
- Fetch:
  - READ_LAT=0: instr = mem[pc_output] combinationally when state!=CLEAR, else 0. instr_valid = (state!=CLEAR).
  - READ_LAT=1: instr and instr_valid are registered from the same terms. There is one cycle of latency from pc_output. instr_valid falls one cycle after entering CLEAR and rises one cycle after leaving it.
  - Read-during-write to the same address:
    - READ_LAT=1 returns the old word.
    - READ_LAT=0 shows the new word after the write edge.
- Reset asserted mid-burst or mid-sweep abandons the operation immediately and restarts the full sweep on deassertion.
- load_count saturates at DEPTH (width ADDR_W+1) and does not wrap.

Decomposition:
- Shared package instr_mem_pkg: state enum (CLEAR/IDLE/LOAD), localparam DEPTH derivation, default DATA_W/ADDR_W constants.
- One natural sub-module: instr_mem_array, a single-write-port / single-read-port RAM with a READ_LAT parameter. The write port is muxed between the sweep and the loader.
- FSM, pointers and flags stay in the top module.

Test Plan:
1. Reset/sweep: release inst_reset_n, ADDR_W=8 -> busy=1 for exactly 256 cycles. instr_valid=0 throughout. Afterwards instr=0 at pc 0x00 and at pc 0xFF.
2. Basic load: load_start with base=0x10, beats 0x20080005, 0x2009000A, 0x01095020, last on third beat -> mem[0x10..0x12] hold the words. load_done pulses one cycle after beat 3. load_count=3, overflow=0.
3. Backpressure/gaps: load_valid toggled 1,0,0,1,1 (last) -> exactly 3 writes, to consecutive addresses; load_ready=1 throughout LOAD.
4. Wrap: ADDR_W=4, base=0xE, 4 beats 0xA..0xD -> mem[0xE]=0xA, mem[0xF]=0xB, mem[0x0]=0xC, mem[0x1]=0xD. load_overflow=1 from the beat at 0xF onward.
5. Abort and priority: clear_req on beat 2 of a burst -> no load_done, busy=1 next cycle, all entries 0 after DEPTH cycles. Separately, load_start and clear_req together in IDLE -> CLEAR entered.
6. Latency: READ_LAT=1, pc=0x10 then 0x11 -> instr follows one cycle later. Writing 0x12345678 to pc's address in the same cycle returns the old value, then the new one on the next cycle.
